// File: rtl/pce_pkg.sv
// Shared types and constants for the pattern census engine.
// Holds the FSM state encoding and a small popcount helper used by the top.
package pce_pkg;

    localparam int unsigned NUM_BYTES = 32;
    localparam int unsigned PAT_ADDR  = 32;
    localparam int unsigned RES_ADDR  = 33;
    localparam int unsigned PAT_W     = 5;

    typedef enum logic [2:0] {
        StIdle,
        StLdPat,
        StScan,
        StWr0,
        StWr1,
        StWr2,
        StDone
    } state_e;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int k = 0; k < 8; k++) begin
            c = c + {3'd0, v[k]};
        end
        return c;
    endfunction

endpackage

// File: rtl/window_match.sv
// Combinational comparator: flags every 5-bit window of a 12-bit slice that equals pat.
// hit_o[k] corresponds to window slice_i[k+4:k], so hit_o[7] is [11:7] and hit_o[0] is [4:0].
module window_match
    import pce_pkg::*;
(
    input  logic [11:0]      slice_i,
    input  logic [PAT_W-1:0] pat_i,
    output logic [7:0]       hit_o
);

    always_comb begin
        hit_o = '0;
        for (int k = 0; k < 8; k++) begin
            hit_o[k] = (slice_i[k +: PAT_W] == pat_i);
        end
    end

endmodule

// File: rtl/pattern_count_engine.sv
// Start/ack responder that counts 5-bit pattern occurrences in a 32-byte message held in
// data memory and writes the in-byte, byte-occupancy and whole-string counts back to memory.
module pattern_count_engine #(
    parameter int unsigned NUM_BYTES = pce_pkg::NUM_BYTES,
    parameter int unsigned PAT_ADDR  = pce_pkg::PAT_ADDR,
    parameter int unsigned RES_ADDR  = pce_pkg::RES_ADDR
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       ack,
    output logic       busy,
    output logic [7:0] dm_addr,
    input  logic [7:0] dm_rd_data,
    output logic       dm_wr_en,
    output logic [7:0] dm_wr_data
);

    import pce_pkg::*;

    localparam int unsigned IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    state_e           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [7:0]       prev_q, prev_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       ctb_q, ctb_d;
    logic [7:0]       cto_q, cto_d;
    logic [7:0]       cts_q, cts_d;

    logic [7:0] cross_hit;
    logic [7:0] inb_hit_raw;
    logic [7:0] inb_hit;
    logic [3:0] cross_cnt;
    logic [3:0] inb_cnt;
    logic [3:0] cross_add;
    logic [3:0] inb_add;

    // Windows straddling the previous byte and the current one: {prev,b}[15:11] .. [8:4].
    window_match u_cross (
        .slice_i (
            {prev_q, dm_rd_data[7:4]}),
        .pat_i   (pat_q),
        .hit_o   (cross_hit)
    );

    // Windows fully inside the current byte; only the low four hits are meaningful.
    window_match u_inbyte (
        .slice_i ({4'b0000, dm_rd_data}),
        .pat_i   (pat_q),
        .hit_o   (inb_hit_raw)
    );

    always_comb begin
        inb_hit   = inb_hit_raw & 8'h0F;
        cross_cnt = popcount8(cross_hit);
        inb_cnt   = popcount8(inb_hit);
        // The first byte has no predecessor; the last byte's in-byte windows close the string.
        cross_add = (idx_q != '0) ? cross_cnt : 4'd0;
        inb_add   = (idx_q == LAST_IDX) ? inb_cnt : 4'd0;
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        prev_d  = prev_q;
        idx_d   = idx_q;
        ctb_d   = ctb_q;
        cto_d   = cto_q;
        cts_d   = cts_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLdPat;
                end
            end
            StLdPat: begin
                pat_d   = dm_rd_data[7:3];
                prev_d  = '0;
                idx_d   = '0;
                ctb_d   = '0;
                cto_d   = '0;
                cts_d   = '0;
                state_d = StScan;
            end
            StScan: begin
                ctb_d  = ctb_q + {4'd0, inb_cnt};
                cto_d  = cto_q + {7'd0, (inb_hit != 8'd0)};
                cts_d  = cts_q + {4'd0, cross_add} + {4'd0, inb_add};
                prev_d = dm_rd_data;
                if (idx_q == LAST_IDX) begin
                    state_d = StWr0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StWr0: state_d = StWr1;
            StWr1: state_d = StWr2;
            StWr2: state_d = StDone;
            StDone: begin
                if (start) begin
                    state_d = StLdPat;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            pat_q   <= '0;
            prev_q  <= '0;
            idx_q   <= '0;
            ctb_q   <= '0;
            cto_q   <= '0;
            cts_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            prev_q  <= prev_d;
            idx_q   <= idx_d;
            ctb_q   <= ctb_d;
            cto_q   <= cto_d;
            cts_q   <= cts_d;
        end
    end

    // Memory port mux and status, all decoded from the registered state.
    always_comb begin
        dm_addr    = 8'd0;
        dm_wr_en   = 1'b0;
        dm_wr_data = 8'd0;
        ack        = 1'b0;
        busy       = 1'b0;

        unique case (state_q)
            StIdle: begin
            end
            StLdPat: begin
                dm_addr = 8'(PAT_ADDR);
                busy    = 1'b1;
            end
            StScan: begin
                dm_addr = 8'(idx_q);
                busy    = 1'b1;
            end
            StWr0: begin
                dm_addr    = 8'(RES_ADDR);
                dm_wr_en   = 1'b1;
                dm_wr_data = ctb_q;
                busy       = 1'b1;
            end
            StWr1: begin
                dm_addr    = 8'(RES_ADDR + 1);
                dm_wr_en   = 1'b1;
                dm_wr_data = cto_q;
                busy       = 1'b1;
            end
            StWr2: begin
                dm_addr    = 8'(RES_ADDR + 2);
                dm_wr_en   = 1'b1;
                dm_wr_data = cts_q;
                busy       = 1'b1;
            end
            StDone: begin
                ack = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_pattern_count_engine.sv
// Directed bench for pattern_count_engine with a behavioural data memory beside it.
module tb_pattern_count_engine;

    logic       clk;
    logic       reset;
    logic       start;
    logic       ack;
    logic       busy;
    logic [7:0] dm_addr;
    logic [7:0] dm_rd_data;
    logic       dm_wr_en;
    logic [7:0] dm_wr_data;

    logic [7:0] mem [0:255];
    int n_cmp    = 0;
    int n_fail   = 0;
    int wr_count = 0;

    pattern_count_engine dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ack        (ack),
        .busy       (busy),
        .dm_addr    (dm_addr),
        .dm_rd_data (dm_rd_data),
        .dm_wr_en   (dm_wr_en),
        .dm_wr_data (dm_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dm_rd_data = mem[dm_addr];

    always @(posedge clk) begin
        if (dm_wr_en === 1'b1) begin
            mem[dm_addr] = dm_wr_data;
            wr_count++;
        end
    end

    task automatic load_msg(input logic [7:0] fill, input logic [7:0] pat_byte);
        for (int i = 0; i < 32; i++) mem[i] = fill;
        mem[32] = pat_byte;
        mem[33] = 8'hEE;
        mem[34] = 8'hEE;
        mem[35] = 8'hEE;
    endtask

    // Pulses start for one cycle; lat counts edges after the sampling edge until ack is seen.
    task automatic launch(output int lat);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (ack !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0", ack); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (dm_addr !== 8'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", dm_addr); end
        n_cmp++; if (dm_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got %b want 0", dm_wr_en); end
        n_cmp++; if (dm_wr_data !== 8'd0) begin n_fail++; $display("FAIL reset_wr_data got %0d want 0", dm_wr_data); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_all_zero;
        int lat;
        int w0;
        load_msg(8'h00, 8'h00);
        w0 = wr_count;
        launch(lat);
        n_cmp++; if (lat !== 36) begin n_fail++; $display("FAIL zero_latency got %0d want 36", lat); end
        n_cmp++; if (mem[33] !== 8'd128) begin n_fail++; $display("FAIL zero_ctb got %0d want 128", mem[33]); end
        n_cmp++; if (mem[34] !== 8'd32) begin n_fail++; $display("FAIL zero_cto got %0d want 32", mem[34]); end
        n_cmp++; if (mem[35] !== 8'd252) begin n_fail++; $display("FAIL zero_cts got %0d want 252", mem[35]); end
        n_cmp++; if (wr_count - w0 !== 3) begin n_fail++; $display("FAIL zero_writes got %0d want 3", wr_count - w0); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL done_busy got %b want 0", busy); end
    endtask

    task automatic test_alternating;
        int lat;
        load_msg(8'h55, 8'hA8);
        launch(lat);
        n_cmp++; if (lat !== 36) begin n_fail++; $display("FAIL alt_latency got %0d want 36", lat); end
        n_cmp++; if (mem[33] !== 8'd64) begin n_fail++; $display("FAIL alt_ctb got %0d want 64", mem[33]); end
        n_cmp++; if (mem[34] !== 8'd32) begin n_fail++; $display("FAIL alt_cto got %0d want 32", mem[34]); end
        n_cmp++; if (mem[35] !== 8'd126) begin n_fail++; $display("FAIL alt_cts got %0d want 126", mem[35]); end
    endtask

    task automatic test_no_match;
        int lat;
        load_msg(8'h00, 8'hF8);
        launch(lat);
        n_cmp++; if (mem[33] !== 8'd0) begin n_fail++; $display("FAIL nomatch_ctb got %0d want 0", mem[33]); end
        n_cmp++; if (mem[34] !== 8'd0) begin n_fail++; $display("FAIL nomatch_cto got %0d want 0", mem[34]); end
        n_cmp++; if (mem[35] !== 8'd0) begin n_fail++; $display("FAIL nomatch_cts got %0d want 0", mem[35]); end
    endtask

    task automatic test_cross_byte;
        int lat;
        load_msg(8'h00, 8'hF8);
        mem[0] = 8'h07;
        mem[1] = 8'hC0;
        launch(lat);
        n_cmp++; if (mem[33] !== 8'd0) begin n_fail++; $display("FAIL cross_ctb got %0d want 0", mem[33]); end
        n_cmp++; if (mem[34] !== 8'd0) begin n_fail++; $display("FAIL cross_cto got %0d want 0", mem[34]); end
        n_cmp++; if (mem[35] !== 8'd1) begin n_fail++; $display("FAIL cross_cts got %0d want 1", mem[35]); end
    endtask

    task automatic test_reset_mid_scan;
        int lat;
        int w0;
        load_msg(8'h00, 8'h00);
        w0 = wr_count;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        n_cmp++; if (dm_addr !== 8'd10) begin n_fail++; $display("FAIL midscan_addr got %0d want 10", dm_addr); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midscan_busy got %b want 1", busy); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        n_cmp++; if (dm_addr !== 8'd0) begin n_fail++; $display("FAIL rst_mid_addr got %0d want 0", dm_addr); end
        repeat (3) @(negedge clk);
        n_cmp++; if (wr_count - w0 !== 0) begin n_fail++; $display("FAIL rst_mid_writes got %0d want 0", wr_count - w0); end
        n_cmp++; if (mem[33] !== 8'hEE) begin n_fail++; $display("FAIL rst_mid_mem got %0d want 238", mem[33]); end
        load_msg(8'hFF, 8'hF8);
        launch(lat);
        n_cmp++; if (lat !== 36) begin n_fail++; $display("FAIL ones_latency got %0d want 36", lat); end
        n_cmp++; if (mem[33] !== 8'd128) begin n_fail++; $display("FAIL ones_ctb got %0d want 128", mem[33]); end
        n_cmp++; if (mem[34] !== 8'd32) begin n_fail++; $display("FAIL ones_cto got %0d want 32", mem[34]); end
        n_cmp++; if (mem[35] !== 8'd252) begin n_fail++; $display("FAIL ones_cts got %0d want 252", mem[35]); end
    endtask

    task automatic test_start_during_scan;
        int lat;
        int w0;
        load_msg(8'h00, 8'h00);
        w0 = wr_count;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (ack !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
            start = (lat == 5);
        end
        start = 1'b0;
        n_cmp++; if (lat !== 36) begin n_fail++; $display("FAIL ign_latency got %0d want 36", lat); end
        n_cmp++; if (wr_count - w0 !== 3) begin n_fail++; $display("FAIL ign_writes got %0d want 3", wr_count - w0); end
        n_cmp++; if (mem[35] !== 8'd252) begin n_fail++; $display("FAIL ign_cts got %0d want 252", mem[35]); end
    endtask

    task automatic test_back_to_back;
        int lat;
        n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL b2b_pre_ack got %b want 1", ack); end
        mem[33] = 8'hEE;
        mem[34] = 8'hEE;
        mem[35] = 8'hEE;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL b2b_ack_drop got %b want 0", ack); end
        n_cmp++; if (dm_addr !== 8'd32) begin n_fail++; $display("FAIL b2b_ldpat_addr got %0d want 32", dm_addr); end
        lat = 0;
        while (ack !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++; if (lat !== 36) begin n_fail++; $display("FAIL b2b_latency got %0d want 36", lat); end
        n_cmp++; if (mem[33] !== 8'd128) begin n_fail++; $display("FAIL b2b_ctb got %0d want 128", mem[33]); end
        n_cmp++; if (mem[34] !== 8'd32) begin n_fail++; $display("FAIL b2b_cto got %0d want 32", mem[34]); end
        n_cmp++; if (mem[35] !== 8'd252) begin n_fail++; $display("FAIL b2b_cts got %0d want 252", mem[35]); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset = 1'b1;
        start = 1'b0;
        test_reset();
        test_all_zero();
        test_alternating();
        test_no_match();
        test_cross_byte();
        test_reset_mid_scan();
        test_start_during_scan();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_count_engine.md
# pattern_count_engine

Hardware responder for the program-3 start/ack handshake. It performs the 5-bit pattern census directly in logic rather than by executing instructions. The pattern is read from data memory byte 32 (bits 7:3) and the 32-byte message from bytes 0–31, with byte 0 as the most significant byte of the 256-bit string. The three counts are written to bytes 33, 34 and 35, then ack is raised. It sits beside the data memory and attaches to that memory's single address port.

## Interface
Parameters:
- NUM_BYTES, 32, message length in bytes.
- PAT_ADDR, 32, data-memory address of the pattern byte.
- RES_ADDR, 33, first result address; results go to RES_ADDR, RES_ADDR+1, RES_ADDR+2.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled high in IDLE or DONE to begin a run.
- ack  out  1  high in DONE; held until the next accepted start or reset.
- busy  out  1  high from the accepted start until DONE.
- dm_addr  out  8  data-memory address (read and write share it).
- dm_rd_data  in  8  data-memory read data; combinational, valid in the same cycle as dm_addr.
- dm_wr_en  out  1  write strobe for one cycle per result.
- dm_wr_data  out  8  write data.

## Operation
- States and transitions:
  - IDLE → LDPAT when start=1.
  - LDPAT (dm_addr=PAT_ADDR; pat ← dm_rd_data[7:3]; clear ctb, cto, cts, prev) → SCAN.
  - SCAN, index i from 0 to 31 with dm_addr=i, one byte per cycle; after i=31 → WR0.
  - WR0 (addr 33, data ctb) → WR1 (addr 34, data cto) → WR2 (addr 35, data cts) → DONE.
  - DONE: ack=1. If start=1, go to LDPAT and drop ack.
- Per SCAN byte b=dm_rd_data:
  - ctb += number of windows among b[4:0], b[5:1], b[6:2], b[7:3] that equal pat (0–4).
  - cto += 1 if that number is nonzero.
  - For i≥1: w={prev,b}. cts += number of windows among w[15:11], w[14:10], …, w[8:4] (8 windows) that equal pat.
  - For i=31 only, also add the 4 in-byte matches of b to cts.
  - prev ← b.
- Window coverage: 31×8+4 = 252 windows, i.e. bit positions 0–251 of the MSB-first string.
- Widths: all counters are 8 bits.
  - ctb max 128, cto max 32, cts max 252, so none can overflow.
  - Any compare-count adder is at least 4 bits.
- start while busy (LDPAT, SCAN or WR*) is ignored.
- Reset at any time:
  - state ← IDLE; counters, pat and prev cleared.
  - Any pending write is abandoned; memory contents written earlier are not rolled back.

## Timing
- Reset values: ack=0, busy=0, dm_addr=0, dm_wr_en=0, dm_wr_data=0.
- Let E0 be the edge that samples start=1:
  - After E0: LDPAT.
  - After E1–E32: SCAN i=0–31.
  - After E33, E34, E35: WR0, WR1, WR2.
  - After E36: DONE, ack=1.
- Latency is 36 cycles from the start sample to ack.
- dm_wr_en is high only in WR0, WR1 and WR2. The write occurs at the edge that ends each of those states.
- busy=1 in LDPAT, SCAN and WR*; busy=0 in IDLE and DONE.
- ack and busy are decoded from the registered state, so they are glitch-free.
- A start pulse of one cycle is sufficient; a level start held high re-launches on every DONE.

## Structure
- Package pce_pkg holds:
  - the state enum (IDLE, LDPAT, SCAN, WR0, WR1, WR2, DONE);
  - constants NUM_BYTES, PAT_ADDR, RES_ADDR and PAT_W=5.
- Sub-module window_match is combinational.
  - Inputs: a 12-bit slice and pat.
  - Outputs: an 8-bit hit vector for windows [11:7] down to [4:0].
  - Instantiate it twice: once on {prev,b[7:4]} for the cross-byte windows, once on {4'b0,b} and masked to its low 4 hits for the in-byte windows.
- The top holds the FSM, the counters and the memory muxing.

## Test plan
- Message all 0x00, pattern 00000 → mem[33]=128, mem[34]=32, mem[35]=252; ack rises exactly 36 cycles after the start sample.
- Message all 0x55, pattern 10101 → mem[33]=64, mem[34]=32, mem[35]=126.
- Message all 0x00, pattern 11111 → mem[33]=0, mem[34]=0, mem[35]=0.
- Byte 0=0x07, byte 1=0xC0, rest 0x00, pattern 11111 → mem[33]=0, mem[34]=0, mem[35]=1 (a byte-crossing-only match).
- Assert reset at SCAN i=10, then start a run on all 0xFF with pattern 11111 → no write occurs before the restart; results are 128, 32, 252.
- Pulse start during SCAN → it is ignored and ack timing is unchanged. Pulse start in DONE → ack drops next cycle and a second identical run rewrites the same results.
